// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with valid/ready handshakes.
// Converts one bit per clock and also reports the count of significant digits.
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH  = 8,
  parameter int BCD_DIGITS = (BIN_WIDTH*3)/10+1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [BIN_WIDTH-1:0]               bin,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [4*BCD_DIGITS-1:0]            bcd,
  output logic [$clog2(BCD_DIGITS+1)-1:0]    ndigits,
  output logic                               busy
);

  localparam int CNT_W = $clog2(BIN_WIDTH+1);
  localparam int ND_W  = $clog2(BCD_DIGITS+1);
  localparam int SH_W  = 4*BCD_DIGITS + BIN_WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_WIDTH-1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [SH_W-1:0]   sh;
  logic [SH_W-1:0]   sh_adj;
  logic [SH_W-1:0]   sh_next;
  logic [4*BCD_DIGITS-1:0] bcd_next;
  logic [ND_W-1:0]   nd_next;

  // One double-dabble step: add 3 to every digit >= 5, then shift left.
  always_comb begin
    sh_adj = sh;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (sh[BIN_WIDTH+4*i +: 4] >= 4'd5)
        sh_adj[BIN_WIDTH+4*i +: 4] = sh[BIN_WIDTH+4*i +: 4] + 4'd3;
    end
    sh_next  = {sh_adj[SH_W-2:0], 1'b0};
    bcd_next = sh_next[SH_W-1 -: 4*BCD_DIGITS];
    nd_next  = ND_W'(1);
    for (int i = 1; i < BCD_DIGITS; i++) begin
      if (bcd_next[4*i +: 4] != 4'd0)
        nd_next = ND_W'(i+1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sh        <= '0;
      bcd       <= '0;
      ndigits   <= ND_W'(1);
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sh       <= SH_W'(bin);
            cnt      <= '0;
            state    <= CONV;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CONV: begin
          sh  <= sh_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            bcd       <= bcd_next;
            ndigits   <= nd_next;
          end
        end
        DONE: begin
          // Release only; the next accept is one cycle later via in_ready.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and randomised checks of bin_to_bcd_seq at BIN_WIDTH 8 and 16.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  bin;
  logic [11:0] bcd;
  logic [1:0]  ndigits;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
  logic [15:0] bin16;
  logic [19:0] bcd16;
  logic [2:0]  nd16;

  int checks = 0;
  int fails  = 0;
  int lat, bsy;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .bin(bin), .out_valid(out_valid), .out_ready(out_ready), .bcd(bcd),
    .ndigits(ndigits), .busy(busy)
  );

  bin_to_bcd_seq #(.BIN_WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .bin(bin16), .out_valid(out_valid16), .out_ready(out_ready16), .bcd(bcd16),
    .ndigits(nd16), .busy(busy16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_bcd(input int v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_nd(input int v);
    if (v >= 10000) return 5;
    if (v >= 1000)  return 4;
    if (v >= 100)   return 3;
    if (v >= 10)    return 2;
    return 1;
  endfunction

  // Starts at a negedge; returns at the negedge where out_valid is first seen.
  // inject >= 0 drives bin=42 with in_valid during that CONV sample.
  task automatic conv8(input logic [7:0] v, input int inject, output int l, output int b);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", 32'(guard < 100), 32'd1);
    in_valid = 1'b1;
    bin = v;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    l = 0;
    b = 0;
    while (!out_valid && l < 100) begin
      if (busy) b++;
      if (l == inject) begin
        in_valid = 1'b1;
        bin = 8'd42;
      end else begin
        in_valid = 1'b0;
        bin = v;
      end
      @(negedge clk);
      l++;
    end
    in_valid = 1'b0;
  endtask

  task automatic basic(input int v);
    conv8(8'(v), -1, lat, bsy);
    check($sformatf("lat_%0d", v), 32'(lat), 32'd8);
    check($sformatf("bcd_%0d", v), 32'(bcd), ref_bcd(v));
    check($sformatf("nd_%0d", v), 32'(ndigits), ref_nd(v));
    @(negedge clk);
    check($sformatf("released_%0d", v), 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; bin = '0; out_ready = 1'b1;
    in_valid16 = 1'b0; bin16 = '0; out_ready16 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_bcd", 32'(bcd), 32'h0);
    check("rst_nd", 32'(ndigits), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 255: latency, busy duration, release timing
    conv8(8'd255, -1, lat, bsy);
    check("lat_255", 32'(lat), 32'd8);
    check("busy_cycles_255", 32'(bsy), 32'd8);
    check("bcd_255", 32'(bcd), 32'h255);
    check("nd_255", 32'(ndigits), 32'd3);
    check("in_ready_in_done", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);

    basic(0);
    basic(9);
    basic(99);
    basic(100);

    // Backpressure
    out_ready = 1'b0;
    conv8(8'd173, -1, lat, bsy);
    check("bcd_173", 32'(bcd), 32'h173);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_bcd", 32'(bcd), 32'h173);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_hold_after_release", 32'(bcd), 32'h173);

    // in_valid during CONV is ignored
    conv8(8'd200, 3, lat, bsy);
    check("spurious_lat", 32'(lat), 32'd8);
    check("spurious_bcd", 32'(bcd), 32'h200);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_extra_busy", 32'(busy), 32'd0);
      check("no_extra_in_ready", 32'(in_ready), 32'd1);
    end

    // Reset in the middle of a conversion
    in_valid = 1'b1;
    bin = 8'd250;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_bcd", 32'(bcd), 32'h0);
    check("mid_rst_nd", 32'(ndigits), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_rst_in_ready", 32'(in_ready), 32'd1);
    basic(7);

    // Random sweep against the decimal reference
    for (int i = 0; i < 1000; i++) begin
      int v;
      v = int'($urandom_range(0, 255));
      conv8(8'(v), -1, lat, bsy);
      check("rand_bcd", 32'(bcd), ref_bcd(v));
      check("rand_nd", 32'(ndigits), ref_nd(v));
      @(negedge clk);
    end

    // 16-bit instance
    check("w16_in_ready", 32'(in_ready16), 32'd1);
    in_valid16 = 1'b1;
    bin16 = 16'd65535;
    @(posedge clk);
    @(negedge clk);
    in_valid16 = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("w16_lat", 32'(lat), 32'd16);
    check("w16_bcd", 32'(bcd16), 32'h65535);
    check("w16_nd", 32'(nd16), 32'd5);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
